// File: rtl/button_toggle_debouncer_pkg.sv
// Shared definitions for the push-button debouncer.
// Contents:
//   deb_state_e             - per-channel debounce FSM encoding (2 bits)
//   DEFAULT_DEBOUNCE_CYCLES - 20 ms of stable level at a 50 MHz clock
//   cnt_width()             - counter width for a given debounce length, never below 1
package button_toggle_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } deb_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  // $clog2 returns 0 for a debounce length of 1; a zero-width counter is not legal.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/button_toggle_debouncer_debounce_channel.sv
// One button channel: 2-FF synchroniser, polarity normalisation, debounce FSM
// with its own stability counter, and a registered press pulse.
// Ports:
//   clk        - rising-edge clock
//   sync_reset - synchronous active-high reset
//   button_raw - asynchronous raw pin level
//   toggle     - one-cycle pulse when a press is accepted
//   pressed    - debounced level, 1 while the press is accepted as held
module debounce_channel
  import button_toggle_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic button_raw,
  output logic toggle,
  output logic pressed
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Level of the pin when the button is released.
  localparam logic             IDLE_LEVEL = ACTIVE_LOW;

  logic             sync1_reg;
  logic             sync2_reg;
  logic             s;
  deb_state_e       state_reg;
  deb_state_e       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             toggle_reg;
  logic             toggle_next;
  logic             pressed_reg;
  logic             pressed_next;

  // s = 1 means "pressed" regardless of pin polarity.
  assign s = sync2_reg ^ IDLE_LEVEL;

  // State register, synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sync1_reg   <= IDLE_LEVEL;
      sync2_reg   <= IDLE_LEVEL;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      toggle_reg  <= 1'b0;
      pressed_reg <= 1'b0;
    end else begin
      sync1_reg   <= button_raw;
      sync2_reg   <= sync1_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      toggle_reg  <= toggle_next;
      pressed_reg <= pressed_next;
    end
  end

  // Next-state logic. Any level reversal inside a debounce state drops back
  // to the stable state and clears the counter, so cnt never passes CNT_LAST.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (s) begin
          state_next = DEB_PRESS;
          cnt_next   = '0;
        end
      end
      DEB_PRESS: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_next = DEB_RELEASE;
          cnt_next   = '0;
        end
      end
      DEB_RELEASE: begin
        if (s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output logic: the pulse marks only the DEB_PRESS -> PRESSED transition,
  // so a bounce during release (DEB_RELEASE -> PRESSED) never re-fires it.
  always_comb begin
    toggle_next  = (state_reg == DEB_PRESS) && (state_next == PRESSED);
    pressed_next = (state_next == PRESSED) || (state_next == DEB_RELEASE);
  end

  assign toggle  = toggle_reg;
  assign pressed = pressed_reg;

endmodule

// File: rtl/button_toggle_debouncer.sv
// Debounces WIDTH raw push-button pins into clean single-cycle toggle pulses
// for the blinking-diode controller, plus debounced held levels.
// Ports:
//   clk        - rising-edge clock
//   sync_reset - synchronous active-high reset, all channels
//   button_raw - asynchronous raw pin levels [WIDTH]
//   toggle     - one-cycle pulse per accepted press [WIDTH]
//   pressed    - debounced held level [WIDTH]
module button_toggle_debouncer
  import button_toggle_debouncer_pkg::*;
#(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [WIDTH-1:0] button_raw,
  output logic [WIDTH-1:0] toggle,
  output logic [WIDTH-1:0] pressed
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_chan (
        .clk        (clk),
        .sync_reset (sync_reset),
        .button_raw (button_raw[gi]),
        .toggle     (toggle[gi]),
        .pressed    (pressed[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_toggle_debouncer.sv
module tb_button_toggle_debouncer;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic [2:0] button_raw;
  logic [2:0] toggle;
  logic [2:0] pressed;
  logic [0:0] raw_hi;
  logic [0:0] toggle_hi;
  logic [0:0] pressed_hi;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_toggle_debouncer #(
    .WIDTH           (3),
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .button_raw (button_raw),
    .toggle     (toggle),
    .pressed    (pressed)
  );

  // Active-high pin variant, single channel.
  button_toggle_debouncer #(
    .WIDTH           (1),
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW      (1'b0)
  ) dut_hi (
    .clk        (clk),
    .sync_reset (sync_reset),
    .button_raw (raw_hi),
    .toggle     (toggle_hi),
    .pressed    (pressed_hi)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] raw;
    logic [2:0] tog;
    logic [2:0] prs;
    logic       rh;
    logic       tog_h;
    logic       prs_h;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic rst, input logic [2:0] raw,
                     input logic [2:0] tog, input logic [2:0] prs,
                     input logic rh, input logic tog_h, input logic prs_h);
    vec_t v;
    v.name = name; v.rst = rst; v.raw = raw; v.tog = tog; v.prs = prs;
    v.rh = rh; v.tog_h = tog_h; v.prs_h = prs_h;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then check outputs 1 ns later.
  task automatic step(input string name, input logic rst, input logic [2:0] raw,
                      input logic [2:0] tog, input logic [2:0] prs,
                      input logic rh, input logic tog_h, input logic prs_h);
    sync_reset = rst;
    button_raw = raw;
    raw_hi     = rh;
    @(posedge clk);
    #1;
    total++;
    if ({toggle, pressed} !== {tog, prs}) begin
      bad++;
      $display("FAIL %s main: got toggle=%b pressed=%b, want toggle=%b pressed=%b",
               name, toggle, pressed, tog, prs);
    end
    total++;
    if ({toggle_hi, pressed_hi} !== {tog_h, prs_h}) begin
      bad++;
      $display("FAIL %s hi: got toggle=%b pressed=%b, want toggle=%b pressed=%b",
               name, toggle_hi, pressed_hi, tog_h, prs_h);
    end
    $display("step %s rst=%b raw=%b raw_hi=%b -> toggle=%b pressed=%b toggle_hi=%b pressed_hi=%b",
             name, rst, raw, rh, toggle, pressed, toggle_hi, pressed_hi);
  endtask

  initial begin
    sync_reset = 1'b1;
    button_raw = 3'b111;
    raw_hi     = 1'b0;

    // Reset, then idle with all buttons released.
    for (int k = 1; k <= 2; k++) add("reset", 1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) add("idle", 1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    // Clean press on channel 0: pin low from edge 1 for 20 cycles.
    // Pulse after edge 7; release starts at edge 21, pressed drops after edge 27.
    for (int k = 1; k <= 30; k++)
      add("clean", 1'b0, (k <= 20) ? 3'b110 : 3'b111,
          (k == 7) ? 3'b001 : 3'b000,
          (k >= 7 && k <= 26) ? 3'b001 : 3'b000,
          1'b0, 1'b0, 1'b0);

    // Simultaneous press on all channels for 10 cycles, then release.
    for (int k = 1; k <= 20; k++)
      add("simul", 1'b0, (k <= 10) ? 3'b000 : 3'b111,
          (k == 7) ? 3'b111 : 3'b000,
          (k >= 7 && k <= 16) ? 3'b111 : 3'b000,
          1'b0, 1'b0, 1'b0);

    // Active-high variant: pin high for 10 cycles, then low.
    for (int k = 1; k <= 20; k++)
      add("polarity", 1'b0, 3'b111, 3'b000, 3'b000,
          (k <= 10), (k == 7), (k >= 7 && k <= 16));

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].rst, vecs[i].raw, vecs[i].tog, vecs[i].prs,
           vecs[i].rh, vecs[i].tog_h, vecs[i].prs_h);

    // Bounce on channel 1: low 3, high 1, low 3, then high -> never accepted.
    for (int k = 1; k <= 11; k++)
      step("bounce", 1'b0, ((k <= 3) || (k >= 5 && k <= 7)) ? 3'b101 : 3'b111,
           3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    // Then a steady 10-cycle press -> exactly one pulse.
    for (int k = 1; k <= 20; k++)
      step("bounce_hold", 1'b0, (k <= 10) ? 3'b101 : 3'b111,
           (k == 7) ? 3'b010 : 3'b000,
           (k >= 7 && k <= 16) ? 3'b010 : 3'b000,
           1'b0, 1'b0, 1'b0);

    // Reset mid-debounce on channel 2: reset at edge 5 while held.
    for (int k = 1; k <= 4; k++)
      step("midrst_pre", 1'b0, 3'b011, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    step("midrst_rst", 1'b1, 3'b011, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    // Still held after reset: counts as a new press from the first edge after deassertion.
    for (int k = 1; k <= 20; k++)
      step("midrst_post", 1'b0, (k <= 10) ? 3'b011 : 3'b111,
           (k == 7) ? 3'b100 : 3'b000,
           (k >= 7 && k <= 16) ? 3'b100 : 3'b000,
           1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_toggle_debouncer.md
# button_toggle_debouncer

Input-side counterpart of the blinking-diode controller: takes raw, bouncy push-button levels from the DE0 board and produces the clean, single-cycle `toggle_diode` pulses that the controller consumes. Each channel is synchronised, debounced with a per-channel counter and state machine, and edge-converted, so one physical press yields exactly one pulse. It sits between the board pins and the diode controller in the top level.

## Interface
- `WIDTH`, 3, number of independent button channels.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range ≥ 1.
- `ACTIVE_LOW`, 1, 1 = button pin reads 0 when pressed (DE0 keys); 0 = active-high pins.
- `clk` input 1 — single clock domain, all logic on rising edge.
- `sync_reset` input 1 — synchronous, active-high reset.
- `button_raw` input WIDTH — asynchronous raw pin levels.
- `toggle` output WIDTH — one-cycle pulse per accepted press; connects to `toggle_diode`.
- `pressed` output WIDTH — debounced level, 1 while the button is accepted as held.

## Operation
- Per channel: 2-FF synchroniser, then polarity normalisation (`s` = 1 means pressed), then FSM with counter `cnt`, width $clog2(DEBOUNCE_CYCLES), minimum 1 bit.
- FSM states: IDLE, DEB_PRESS, PRESSED, DEB_RELEASE.
  - IDLE: `s`=1 → DEB_PRESS, `cnt`←0.
  - DEB_PRESS: `s`=0 → IDLE, `cnt`←0; `s`=1 and `cnt`==DEBOUNCE_CYCLES-1 → PRESSED, `toggle`←1; otherwise `cnt`++.
  - PRESSED: `s`=0 → DEB_RELEASE, `cnt`←0.
  - DEB_RELEASE: `s`=1 → PRESSED, `cnt`←0; `s`=0 and `cnt`==DEBOUNCE_CYCLES-1 → IDLE; otherwise `cnt`++.
- `toggle` is registered and high for exactly one cycle per IDLE→…→PRESSED entry; it is never asserted on release.
- `pressed` is registered; 1 in PRESSED and DEB_RELEASE, 0 otherwise.
- Channels are fully independent. Simultaneous presses on several channels produce pulses in the same cycle.
- A bounce (any `s` reversal) during a debounce state aborts it and restarts counting from 0 on the next qualifying level. The counter never wraps, because it is cleared before it can reach DEBOUNCE_CYCLES.
- Reset applies to all channels and overrides all other activity, including mid-debounce:
  - FSM returns to IDLE, `cnt`=0.
  - Synchroniser FFs load the inactive pin level: 1 if ACTIVE_LOW, else 0.
  - `toggle`=0 and `pressed`=0.
- If a button is held while reset deasserts, it is treated as a new press and produces one pulse after the normal latency.

## Timing
- Number the first rising edge that samples the new pin level as edge 1. With a clean, stable press:
  - DEB_PRESS is entered at edge 3.
  - `toggle` goes high after edge DEBOUNCE_CYCLES+3 and low after edge DEBOUNCE_CYCLES+4.
  - `pressed` rises together with `toggle`.
- Release: `pressed` falls after edge DEBOUNCE_CYCLES+3, counted from the first edge that samples the released level.
- Minimum accepted press is DEBOUNCE_CYCLES+1 consecutive synchronised pressed samples. Anything shorter produces no `toggle` and no `pressed`.
- During reset, outputs are 0 from the first edge with `sync_reset`=1. Processing of `button_raw` resumes with the first edge after deassertion, which counts as edge 1.

## Structure
- Shared package (same one that holds the existing `REG_CTRL_*` defines):
  - FSM state encoding: IDLE, DEB_PRESS, PRESSED, DEB_RELEASE, in 2 bits.
  - Default debounce constant for 50 MHz, 20 ms.
- Sub-module `debounce_channel` holds one synchroniser, FSM and counter, and exposes `toggle`/`pressed` bits. The top generates WIDTH instances and passes ACTIVE_LOW and DEBOUNCE_CYCLES to each.
- The counter is local to `debounce_channel`. It does not reuse the shared `register` block, because its clear condition depends on FSM state.

## Test plan
All scenarios use WIDTH=3, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
- Reset: `sync_reset`=1 for 2 cycles with `button_raw`=3'b111 → `toggle`=000 and `pressed`=000. No pulses follow while the buttons stay released.
- Clean press: `button_raw[0]` goes to 0 at edge 1 and is held for 20 cycles → `toggle`=001 for exactly the cycle after edge 7; `pressed[0]`=1 from edge 7. Release → `pressed[0]`=0 after the 7th edge of release, with no `toggle` on release.
- Bounce: `button_raw[1]` is low 3 cycles, high 1, low 3, high → no `toggle[1]` and no `pressed[1]`. Then low for 10 cycles → exactly one `toggle[1]` pulse.
- Simultaneous press: all three bits go low at the same edge → `toggle`=111 in one single cycle, then 000.
- Reset mid-debounce: `button_raw[2]` low, and `sync_reset` pulses at edge 5 → no pulse before reset. One pulse occurs 7 edges after reset deasserts, because the button is still held.
- Polarity: ACTIVE_LOW=0 and `button_raw[0]` high for 10 cycles → one pulse after edge 7.
